// File: rtl/wordlines_pulse_n.sv
// Pulsed wordline driver: one independent IDLE/PULSE/RECOVER sequencer per read
// port and for the write port, plus a sticky read/write same-row collision flag.

// state   | meaning
// IDLE    | ready; accept captures row and pulse length
// PULSE   | wordline high; down-counter runs to terminal count 0
// RECOVER | one dead cycle before the port is ready again
module wl_port_fsm #(
  parameter int ROWS     = 64,
  parameter int HALF_SEL = 0,
  localparam int AW      = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic [AW-1:0]   addr,
  input  logic [2:0]      pulse_len,
  output logic            rdy,
  output logic [ROWS-1:0] wl_l,
  output logic [ROWS-1:0] wl_r
);

  typedef enum logic [1:0] {IDLE, PULSE, RECOVER} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [ROWS-1:0] wl_l_q, wl_l_d, wl_r_q, wl_r_d;
  logic [AW-1:0]   sel_addr;
  logic [ROWS-1:0] onehot;
  logic            drive;
  logic [2:0]      len_m1;

  // A zero length still gives a one-cycle pulse.
  assign len_m1 = (pulse_len == 3'd0) ? 3'd0 : pulse_len - 3'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    drive    = 1'b0;
    sel_addr = addr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d  = PULSE;
          addr_d   = addr;
          cnt_d    = len_m1;
          drive    = 1'b1;
          sel_addr = addr;
        end
      end
      PULSE: begin
        if (cnt_q == 3'd0) begin
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q - 3'd1;
          drive = 1'b1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    onehot = drive ? ({{(ROWS-1){1'b0}}, 1'b1} << sel_addr) : '0;
    if (HALF_SEL != 0) begin
      wl_l_d = sel_addr[AW-1] ? '0 : onehot;
      wl_r_d = sel_addr[AW-1] ? onehot : '0;
    end else begin
      wl_l_d = onehot;
      wl_r_d = onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wl_l_q  <= '0;
      wl_r_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wl_l_q  <= wl_l_d;
      wl_r_q  <= wl_r_d;
    end
  end

  assign rdy  = (state_q == IDLE);
  assign wl_l = wl_l_q;
  assign wl_r = wl_r_q;

endmodule

module wordlines_pulse_n #(
  parameter int NRD      = 2,
  parameter int ROWS     = 64,
  parameter int HALF_SEL = 0,
  localparam int AW      = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD-1:0]      rd_req,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD-1:0]      rd_rdy,
  output logic [NRD*ROWS-1:0] rwl_l,
  output logic [NRD*ROWS-1:0] rwl_r,
  input  logic                wr_req,
  input  logic [AW-1:0]       wr_addr,
  output logic                wr_rdy,
  output logic [ROWS-1:0]     wwl_l,
  output logic [ROWS-1:0]     wwl_r,
  input  logic [2:0]          pulse_len,
  output logic                coll,
  input  logic                coll_clr
);

  logic coll_q, coll_d, hit;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    wl_port_fsm #(.ROWS(ROWS), .HALF_SEL(HALF_SEL)) u_rd (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (rd_req[p]),
      .addr      (rd_addr[p*AW +: AW]),
      .pulse_len (pulse_len),
      .rdy       (rd_rdy[p]),
      .wl_l      (rwl_l[p*ROWS +: ROWS]),
      .wl_r      (rwl_r[p*ROWS +: ROWS])
    );
  end

  wl_port_fsm #(.ROWS(ROWS), .HALF_SEL(HALF_SEL)) u_wr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (wr_req),
    .addr      (wr_addr),
    .pulse_len (pulse_len),
    .rdy       (wr_rdy),
    .wl_l      (wwl_l),
    .wl_r      (wwl_r)
  );

  // Observed from the registered wordlines, so it never feeds back into them.
  always_comb begin
    hit = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      hit = hit | (|(wwl_l & rwl_l[p*ROWS +: ROWS])) | (|(wwl_r & rwl_r[p*ROWS +: ROWS]));
    end
    coll_d = hit ? 1'b1 : (coll_clr ? 1'b0 : coll_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= coll_d;
  end

  assign coll = coll_q;

endmodule
